seq_mem_param_2r1w_rf_fw: RTL and testbench
===========================================

# seq_mem_param_2r1w_rf_fw

Parametrised register file with two read ports, one write port and per-byte write masking. Both reads are combinational with write-to-read forwarding. A per-entry valid bit, a synchronous clear-all and a valid-entry counter make it usable as a scoreboarded architectural register file. It generalises the 8-entry x 8-bit 1r1w forwarding register file in width, depth and read-port count, and sits inside pipelined datapath blocks that need same-cycle bypass.

## Interface
- p_nbits, default 8: entry width in bits; must be a multiple of 8, minimum 8.
- p_nentries, default 8: number of entries; power of two, minimum 2.
- Derived, not overridable: p_nbytes = p_nbits/8; p_aw = $clog2(p_nentries); p_cw = p_aw+1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  one clock; reset is asynchronous and active-high.
- read_addr0  input  p_aw  read port 0 address.
- read_data0  output  p_nbits  read port 0 data.
- read_valid0  output  1  read port 0 entry-valid.
- read_addr1  input  p_aw  read port 1 address.
- read_data1  output  p_nbits  read port 1 data.
- read_valid1  output  1  read port 1 entry-valid.
- write_en  input  1  write request.
- write_addr  input  p_aw  write address.
- write_data  input  p_nbits  write data.
- write_mask  input  p_nbytes  byte enables; bit i covers bits [8i+7:8i].
- clear  input  1  synchronous invalidate-and-zero of all entries.
- num_valid  output  p_cw  count of valid entries, 0..p_nentries.

## Operation
- State: mem[p_nentries] of p_nbits, valid[p_nentries], count register for num_valid.
- Effective write: we = write_en && (write_mask != 0). A write with an all-zero mask is a no-op: no data change, no valid change, no forwarding.
- Merge: merged(a) has byte i = write_data byte i if write_mask[i], else mem[a] byte i.
- Read port k, evaluated independently for k = 0 and 1:
  - If we && write_addr == read_addrk: read_datak = merged(write_addr), read_validk = 1.
  - Otherwise: read_datak = mem[read_addrk], read_validk = valid[read_addrk].
- Both ports may read the same address in the same cycle; both return identical results.
- clear affects state only at the edge. Same-cycle reads still see pre-clear contents, including forwarding.
- Posedge update:
  - clear only: all mem entries = 0, all valid = 0.
  - we only: mem[write_addr] = merged(write_addr), valid[write_addr] = 1.
  - clear && we: all entries are zeroed and invalidated, except mem[write_addr]. That entry takes unmasked bytes = 0, masked bytes = write_data, and valid = 1.
- num_valid tracks popcount(valid) as an incremental counter, not a combinational popcount:
  - +1 when we targets an invalid entry.
  - Unchanged when we targets a valid entry.
  - clear sets it to 0, or to 1 if we in the same cycle.
  - It never exceeds p_nentries.

## Timing
- Async reset, taking effect immediately without waiting for clk:
  - all mem = 0, all valid = 0, num_valid = 0.
  - read_data0/1 = 0, read_valid0/1 = 0.
  - Writes and forwarding are suppressed while reset is high.
- First write can be accepted on the first posedge after reset deasserts.
- Read latency is 0 cycles, combinational from the address.
- Write-to-read latency:
  - 0 cycles via forwarding in the same cycle.
  - Visible from mem from the cycle after the edge.
- num_valid is registered and reflects writes/clears from the cycle after the edge.
- Reset asserted mid-operation discards any in-flight write at that edge; all state returns to reset values.
- Wrap-around: none. Addresses are full-range because p_nentries is a power of two.

## Test plan
- Reset, then read all addresses on both ports:
  - read_data0/1 = 0, read_valid0/1 = 0, num_valid = 0.
- Defaults (p_nbits=8, p_nentries=8); write 0xA5 to address 3 while both ports read 3:
  - Same cycle: read_data0/1 = 0xA5 (forwarded), read_valid0/1 = 1.
  - Next cycle with write_en=0: read_data = 0xA5, num_valid = 1.
- p_nbits=32; write 0x11223344 with mask 4'b1111 to address 5; next cycle write 0xAABBCCDD with mask 4'b0101 to address 5 while port 1 reads 5:
  - Same cycle: read_data1 = 0x11BB33DD.
  - num_valid stays 1.
  - Mask 4'b0000 write to address 6: read_valid for address 6 stays 0 and num_valid stays 1.
- Fill all 8 entries:
  - num_valid = 8.
  - Rewrite address 0: num_valid stays 8.
  - Assert clear together with a write of 0x7E (full mask) to address 2: next cycle num_valid = 1, only address 2 valid with data 0x7E, all other entries read 0 and invalid.
- Assert reset asynchronously mid-cycle while write_en=1 to address 4 and num_valid = 5:
  - Outputs go to 0 before the next posedge.
  - After deassert, address 4 reads 0 and invalid, and num_valid = 0.

Source files
------------

// File: rtl/seq_mem_param_2r1w_rf_fw.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_param_2r1w_rf_fw
// Brief    : Parametrised 2-read/1-write register file with byte-masked writes,
//            same-cycle write-to-read forwarding, per-entry valid bits,
//            synchronous clear-all and an incremental valid-entry counter.
// Revision : 1.0
// ============================================================================
module seq_mem_param_2r1w_rf_fw #(
    parameter int p_nbits    = 8,
    parameter int p_nentries = 8,
    localparam int p_nbytes  = p_nbits / 8,
    localparam int p_aw      = $clog2(p_nentries),
    localparam int p_cw      = p_aw + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [p_aw-1:0]     read_addr0,
    output logic [p_nbits-1:0]  read_data0,
    output logic                read_valid0,
    input  logic [p_aw-1:0]     read_addr1,
    output logic [p_nbits-1:0]  read_data1,
    output logic                read_valid1,
    input  logic                write_en,
    input  logic [p_aw-1:0]     write_addr,
    input  logic [p_nbits-1:0]  write_data,
    input  logic [p_nbytes-1:0] write_mask,
    input  logic                clear,
    output logic [p_cw-1:0]     num_valid
);

    localparam logic [p_cw-1:0] c_one = p_cw'(1);

    logic [p_nbits-1:0]    r_mem [p_nentries];
    logic [p_nentries-1:0] r_valid;
    logic [p_cw-1:0]       r_count;

    logic                  w_we;
    logic [p_nbits-1:0]    w_cur;
    logic [p_nbits-1:0]    w_fwd_data;
    logic [p_nbits-1:0]    w_wr_data;

    // An all-zero mask is a true no-op; reset suppresses writes and bypass.
    assign w_we  = write_en && (write_mask != '0) && !reset;
    assign w_cur = r_mem[write_addr];

    // Forwarded data merges with pre-clear contents; the stored value merges
    // with zero when a clear lands on the same edge.
    for (genvar b = 0; b < p_nbytes; b++) begin : g_byte
        assign w_fwd_data[8*b +: 8] = write_mask[b] ? write_data[8*b +: 8] : w_cur[8*b +: 8];
        assign w_wr_data[8*b +: 8]  = write_mask[b] ? write_data[8*b +: 8]
                                                    : (clear ? 8'h00 : w_cur[8*b +: 8]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_nentries; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < p_nentries; i++) begin
                    r_mem[i] <= '0;
                end
                r_valid <= '0;
                r_count <= w_we ? c_one : '0;
            end else if (w_we && !r_valid[write_addr]) begin
                r_count <= r_count + c_one;
            end
            if (w_we) begin
                r_mem[write_addr]   <= w_wr_data;
                r_valid[write_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        read_data0  = r_mem[read_addr0];
        read_valid0 = r_valid[read_addr0];
        if (w_we && (write_addr == read_addr0)) begin
            read_data0  = w_fwd_data;
            read_valid0 = 1'b1;
        end
        if (reset) begin
            read_data0  = '0;
            read_valid0 = 1'b0;
        end
    end

    always_comb begin
        read_data1  = r_mem[read_addr1];
        read_valid1 = r_valid[read_addr1];
        if (w_we && (write_addr == read_addr1)) begin
            read_data1  = w_fwd_data;
            read_valid1 = 1'b1;
        end
        if (reset) begin
            read_data1  = '0;
            read_valid1 = 1'b0;
        end
    end

    assign num_valid = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_mem_param_2r1w_rf_fw.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mem_param_2r1w_rf_fw
// Brief    : Self-checking bench for the 2r1w forwarding register file
//            (32-bit x 8 entries) against a behavioural array model.
// Revision : 1.0
// ============================================================================
module tb_seq_mem_param_2r1w_rf_fw;

    localparam int NB = 32;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  read_addr0, read_addr1, write_addr;
    logic [31:0] read_data0, read_data1, write_data;
    logic        read_valid0, read_valid1;
    logic        write_en, clear;
    logic [3:0]  write_mask;
    logic [3:0]  num_valid;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_mem [NE];
    bit          m_valid [NE];

    seq_mem_param_2r1w_rf_fw #(.p_nbits(NB), .p_nentries(NE)) dut (
        .clk(clk), .reset(reset),
        .read_addr0(read_addr0), .read_data0(read_data0), .read_valid0(read_valid0),
        .read_addr1(read_addr1), .read_data1(read_data1), .read_valid1(read_valid1),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .write_mask(write_mask), .clear(clear), .num_valid(num_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] wd, input logic [31:0] base,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? wd[8*b +: 8] : base[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_mem[i] = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic drive(input bit en, input int wa, input logic [31:0] wd, input logic [3:0] wm,
                         input bit clr, input int ra0, input int ra1);
        write_en = en; write_addr = 3'(wa); write_data = wd; write_mask = wm;
        clear = clr; read_addr0 = 3'(ra0); read_addr1 = 3'(ra1);
    endtask

    // Expected combinational read results from the model and current inputs.
    task automatic check_reads(input string tag);
        bit we;
        logic [31:0] e0, e1;
        bit v0, v1;
        #1;
        we = write_en && (write_mask != 0) && !reset;
        e0 = m_mem[read_addr0]; v0 = m_valid[read_addr0];
        e1 = m_mem[read_addr1]; v1 = m_valid[read_addr1];
        if (we && write_addr == read_addr0) begin
            e0 = merge(write_data, m_mem[write_addr], write_mask); v0 = 1'b1;
        end
        if (we && write_addr == read_addr1) begin
            e1 = merge(write_data, m_mem[write_addr], write_mask); v1 = 1'b1;
        end
        chk({tag, ".rd0"}, read_data0, e0);
        chk({tag, ".rv0"}, 32'(read_valid0), 32'(v0));
        chk({tag, ".rd1"}, read_data1, e1);
        chk({tag, ".rv1"}, 32'(read_valid1), 32'(v1));
    endtask

    task automatic tick(input string tag);
        bit we;
        logic [31:0] nd;
        int n;
        we = write_en && (write_mask != 0);
        nd = merge(write_data, clear ? 32'h0 : m_mem[write_addr], write_mask);
        @(posedge clk);
        if (reset) model_reset();
        else begin
            if (clear) model_reset();
            if (we) begin
                m_mem[write_addr] = nd;
                m_valid[write_addr] = 1'b1;
            end
        end
        #1;
        n = 0;
        for (int i = 0; i < NE; i++) n += int'(m_valid[i]);
        chk({tag, ".num_valid"}, 32'(num_valid), 32'(n));
    endtask

    task automatic step(input string tag, input bit en, input int wa, input logic [31:0] wd,
                        input logic [3:0] wm, input bit clr, input int ra0, input int ra1);
        drive(en, wa, wd, wm, clr, ra0, ra1);
        check_reads(tag);
        tick(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset state on every address, both ports.
        for (int a = 0; a < NE; a++) begin
            drive(0, 0, 0, 0, 0, a, NE - 1 - a);
            check_reads("reset");
            chk("reset.rv0", 32'(read_valid0), 32'd0);
        end
        chk("reset.num_valid", 32'(num_valid), 32'd0);

        // Same-cycle forwarding to both ports.
        drive(1, 3, 32'hA5, 4'hF, 0, 3, 3);
        check_reads("fwd");
        chk("fwd.rd0", read_data0, 32'hA5);
        chk("fwd.rd1", read_data1, 32'hA5);
        tick("fwd");
        drive(0, 0, 0, 0, 0, 3, 3);
        check_reads("fwd_after");
        chk("fwd_after.rd0", read_data0, 32'hA5);
        chk("fwd_after.num_valid", 32'(num_valid), 32'd1);
        tick("fwd_after");

        // Byte masking and forwarding of the merged word.
        step("full5", 1, 5, 32'h11223344, 4'hF, 0, 5, 0);
        drive(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 5);
        check_reads("mask5");
        chk("mask5.rd1", read_data1, 32'h11BB33DD);
        tick("mask5");
        chk("mask5.num_valid", 32'(num_valid), 32'd2);
        drive(1, 6, 32'hDEADBEEF, 4'b0000, 0, 6, 6);
        check_reads("zmask");
        chk("zmask.rv0", 32'(read_valid0), 32'd0);
        tick("zmask");
        chk("zmask.num_valid", 32'(num_valid), 32'd2);

        // Fill, rewrite, then clear with simultaneous write.
        for (int a = 0; a < NE; a++) step("fill", 1, a, 32'h100 + 32'(a), 4'hF, 0, a, 7 - a);
        chk("fill.num_valid", 32'(num_valid), 32'd8);
        step("rewrite0", 1, 0, 32'hCAFE0000, 4'b1100, 0, 0, 1);
        chk("rewrite0.num_valid", 32'(num_valid), 32'd8);
        drive(1, 2, 32'h7E, 4'hF, 1, 2, 4);
        check_reads("clrw");
        chk("clrw.rd1_preclear", read_data1, 32'h104);
        tick("clrw");
        chk("clrw.num_valid", 32'(num_valid), 32'd1);
        for (int a = 0; a < NE; a++) begin
            drive(0, 0, 0, 0, 0, a, a);
            check_reads("after_clr");
            chk("after_clr.rv0", 32'(read_valid0), 32'(a == 2));
            chk("after_clr.rd0", read_data0, (a == 2) ? 32'h7E : 32'h0);
        end
        // Clear with a partial mask: unmasked bytes become zero.
        step("pre_clr", 1, 6, 32'hFFFFFFFF, 4'hF, 0, 6, 6);
        step("clr_part", 1, 6, 32'h12345678, 4'b0011, 1, 6, 2);
        step("clr_part_rd", 0, 0, 0, 0, 0, 6, 2);
        chk("clr_part.rd0", read_data0, 32'h00005678);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), $urandom,
                 4'($urandom), 1'($urandom_range(0, 24) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        // Build num_valid = 5 with entry 4 invalid, then async reset mid-cycle.
        step("pre_rst", 0, 0, 0, 0, 1, 0, 0);
        step("pre_rst", 1, 0, 32'h1, 4'hF, 0, 0, 0);
        step("pre_rst", 1, 1, 32'h2, 4'hF, 0, 0, 0);
        step("pre_rst", 1, 3, 32'h3, 4'hF, 0, 0, 0);
        step("pre_rst", 1, 5, 32'h4, 4'hF, 0, 0, 0);
        step("pre_rst", 1, 7, 32'h5, 4'hF, 0, 0, 0);
        chk("pre_rst.num_valid", 32'(num_valid), 32'd5);
        drive(1, 4, 32'h44444444, 4'hF, 0, 4, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async.rd0", read_data0, 32'h0);
        chk("async.rv0", 32'(read_valid0), 32'd0);
        chk("async.rd1", read_data1, 32'h0);
        chk("async.num_valid", 32'(num_valid), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 4, 0);
        check_reads("post_rst");
        chk("post_rst.rv0", 32'(read_valid0), 32'd0);
        chk("post_rst.rd0", read_data0, 32'h0);
        tick("post_rst");
        chk("post_rst.num_valid", 32'(num_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
